// File: rtl/clock_gen_pkg.sv
// Shared constants for the multi-channel clock generator:
// mode encodings, ClockBus bit indices and the channel phase type.
package clock_gen_pkg;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    localparam int CLK      = 0;
    localparam int CLK_N    = 1;
    localparam int POS_TICK = 2;
    localparam int NEG_TICK = 3;
    localparam int GCLK     = 4;
    localparam int CB_W     = 5;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

endpackage

// File: rtl/clock_tick_gen.sv
// Shared tick prescaler: o_tick pulses once every TICK_RELOAD+1 clocks.
// Ports: i_clk, i_rst (async, active high), o_tick.
module clock_tick_gen #(
    parameter int TICK_BITS   = 16,
    parameter int TICK_RELOAD = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam logic [TICK_BITS-1:0] RELOAD = TICK_BITS'(TICK_RELOAD);

    logic [TICK_BITS-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= RELOAD;
        end else if (r_cnt == '0) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - TICK_BITS'(1);
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/multi_clock_gen.sv
// Multi-channel derived clock generator with RUN/HALT/STEP control.
// Ports: FPGA_GlobalClock, FPGA_GlobalReset, Mode, StepReq, ChanEnable,
//        HighTicks, LowTicks (packed per channel), ClockBus (5 bits per
//        channel), StepBusy (per channel).
module multi_clock_gen
    import clock_gen_pkg::*;
#(
    parameter int NR_CHANNELS = 4,
    parameter int TICK_BITS   = 16,
    parameter int TICK_RELOAD = 0,
    parameter int CNT_BITS    = 8
) (
    input  logic                            FPGA_GlobalClock,
    input  logic                            FPGA_GlobalReset,
    input  logic [1:0]                      Mode,
    input  logic                            StepReq,
    input  logic [NR_CHANNELS-1:0]          ChanEnable,
    input  logic [NR_CHANNELS*CNT_BITS-1:0] HighTicks,
    input  logic [NR_CHANNELS*CNT_BITS-1:0] LowTicks,
    output logic [NR_CHANNELS*CB_W-1:0]     ClockBus,
    output logic [NR_CHANNELS-1:0]          StepBusy
);

    logic w_tick;
    logic w_run;
    logic w_step;

    // Mode 11 decodes to neither RUN nor STEP, so it behaves as HALT.
    assign w_run  = (Mode == MODE_RUN);
    assign w_step = (Mode == MODE_STEP);

    clock_tick_gen #(
        .TICK_BITS   (TICK_BITS),
        .TICK_RELOAD (TICK_RELOAD)
    ) u_tick (
        .i_clk  (FPGA_GlobalClock),
        .i_rst  (FPGA_GlobalReset),
        .o_tick (w_tick)
    );

    for (genvar i = 0; i < NR_CHANNELS; i++) begin : g_ch
        phase_t              r_phase;
        phase_t              w_phase_nxt;
        logic [CNT_BITS-1:0] r_cnt;
        logic [CNT_BITS-1:0] w_cnt_nxt;
        logic [CNT_BITS-1:0] r_len;
        logic [CNT_BITS-1:0] w_len_nxt;
        logic [CNT_BITS-1:0] w_len_in;
        logic [CNT_BITS-1:0] w_len;
        logic [CNT_BITS-1:0] w_last;
        logic                r_busy;
        logic                w_busy_nxt;
        logic                w_active;
        logic                w_flip;

        always_comb begin
            w_len_in = (r_phase == PH_HIGH)
                     ? HighTicks[i*CNT_BITS +: CNT_BITS]
                     : LowTicks[i*CNT_BITS +: CNT_BITS];
            // At phase start the live input is the length; it is
            // captured on the first advancing tick and held after.
            w_len    = (r_cnt == '0) ? w_len_in : r_len;
            w_last   = (w_len == '0) ? '0 : w_len - CNT_BITS'(1);
            w_active = w_tick & ChanEnable[i]
                     & (w_run | (w_step & r_busy));
            w_flip   = w_active & (r_cnt == w_last);

            w_phase_nxt = r_phase;
            w_cnt_nxt   = r_cnt;
            w_len_nxt   = r_len;
            w_busy_nxt  = r_busy;

            if (w_active) begin
                if (r_cnt == '0) begin
                    w_len_nxt = w_len_in;
                end
                if (w_flip) begin
                    w_cnt_nxt   = '0;
                    w_phase_nxt = (r_phase == PH_HIGH) ? PH_LOW : PH_HIGH;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_BITS'(1);
                end
            end

            if (!w_step) begin
                w_busy_nxt = 1'b0;
            end else if (r_busy) begin
                if (w_flip && (r_phase == PH_HIGH)) begin
                    w_busy_nxt = 1'b0;
                end
            end else if (StepReq && ChanEnable[i]) begin
                w_busy_nxt = 1'b1;
            end
        end

        always_ff @(posedge FPGA_GlobalClock or posedge FPGA_GlobalReset) begin
            if (FPGA_GlobalReset) begin
                r_phase <= PH_LOW;
                r_cnt   <= '0;
                r_len   <= '0;
                r_busy  <= 1'b0;
            end else begin
                r_phase <= w_phase_nxt;
                r_cnt   <= w_cnt_nxt;
                r_len   <= w_len_nxt;
                r_busy  <= w_busy_nxt;
            end
        end

        assign ClockBus[i*CB_W+CLK]      = (r_phase == PH_HIGH);
        assign ClockBus[i*CB_W+CLK_N]    = (r_phase == PH_LOW);
        assign ClockBus[i*CB_W+POS_TICK] = w_flip & (r_phase == PH_LOW);
        assign ClockBus[i*CB_W+NEG_TICK] = w_flip & (r_phase == PH_HIGH);
        assign ClockBus[i*CB_W+GCLK]     = FPGA_GlobalClock;
        assign StepBusy[i]               = r_busy;
    end

endmodule
